// File: rtl/ame_num_approx.sv
// Power-of-two approximation of |operand|: scans the magnitude MSB-chunk first,
// then rounds the leading-one position and emits a one-hot result plus the operand sign.
module ame_num_approx #(
  parameter int COMP_DATA_BITS = 64,
  parameter int SCAN_BITS      = 8,
  parameter int ROUND_EN       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      comp_init_i,
  input  logic [COMP_DATA_BITS-1:0] comp_data_i,
  output logic                      busy_o,
  output logic                      comp_done_o,
  output logic [COMP_DATA_BITS-1:0] num_approx_o,
  output logic                      num_approx_sign_o,
  output logic [1:0]                dbg_state_o
);

  // Handshake: comp_init_i is a single-cycle request taken only while busy_o=0
  // (state IDLE), with comp_data_i captured on that same edge. Requests seen while
  // busy_o=1 are dropped. comp_done_o is a one-cycle pulse; the result outputs stay
  // valid until the next completion, and a request in the done cycle is accepted.

  localparam int NCH = COMP_DATA_BITS / SCAN_BITS;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (COMP_DATA_BITS > 1) ? $clog2(COMP_DATA_BITS) : 1;
  localparam int QW  = PW + 1;
  localparam int LW  = (SCAN_BITS > 1) ? $clog2(SCAN_BITS) : 1;

  localparam logic [CW-1:0] C_TOP = CW'(NCH - 1);
  localparam logic [QW-1:0] Q_MAX = QW'(COMP_DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;

  logic [1:0]                state_q;
  logic [COMP_DATA_BITS-1:0] mag_q;
  logic                      sign_q;
  logic [CW-1:0]             c_q;
  logic [PW-1:0]             p_q;
  logic                      zero_q;
  logic [COMP_DATA_BITS-1:0] approx_q;
  logic                      approx_sign_q;
  logic                      done_q;

  logic [COMP_DATA_BITS-1:0] comp_abs;
  logic [SCAN_BITS-1:0]      chunk;
  logic                      lead_found;
  logic [LW-1:0]             lead_idx;
  logic [PW-1:0]             scan_p;
  logic                      round_up;
  logic [QW-1:0]             q_ext;
  logic [PW-1:0]             q_sat;
  logic [COMP_DATA_BITS-1:0] approx_next;

  // The most negative operand wraps to 2^(N-1), which is exactly its magnitude.
  always_comb begin
    comp_abs = comp_data_i;
    if (comp_data_i[COMP_DATA_BITS-1]) begin
      comp_abs = (~comp_data_i) + COMP_DATA_BITS'(1);
    end
  end

  // Leading one of the current chunk; the ascending loop leaves the highest index.
  always_comb begin
    chunk      = mag_q[c_q*SCAN_BITS +: SCAN_BITS];
    lead_found = 1'b0;
    lead_idx   = '0;
    for (int i = 0; i < SCAN_BITS; i++) begin
      if (chunk[i]) begin
        lead_found = 1'b1;
        lead_idx   = LW'(i);
      end
    end
    scan_p = PW'(int'(c_q) * SCAN_BITS + int'(lead_idx));
  end

  // Round up when the bit just below the leading one is set; clamp at the MSB.
  always_comb begin
    round_up = 1'b0;
    if ((ROUND_EN != 0) && (p_q != '0)) begin
      round_up = mag_q[p_q - PW'(1)];
    end
    q_ext = {1'b0, p_q} + QW'(round_up);
    q_sat = q_ext[PW-1:0];
    if (q_ext > Q_MAX) begin
      q_sat = PW'(COMP_DATA_BITS - 1);
    end
    approx_next = COMP_DATA_BITS'(1) << q_sat;
    if (zero_q) begin
      approx_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      mag_q         <= '0;
      sign_q        <= 1'b0;
      c_q           <= '0;
      p_q           <= '0;
      zero_q        <= 1'b0;
      approx_q      <= '0;
      approx_sign_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (comp_init_i) begin
            mag_q   <= comp_abs;
            sign_q  <= comp_data_i[COMP_DATA_BITS-1];
            c_q     <= C_TOP;
            p_q     <= '0;
            zero_q  <= 1'b0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (lead_found) begin
            p_q     <= scan_p;
            state_q <= ST_ROUND;
          end else if (c_q != '0) begin
            c_q <= c_q - CW'(1);
          end else begin
            zero_q  <= 1'b1;
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          approx_q      <= approx_next;
          approx_sign_q <= sign_q & ~zero_q;
          done_q        <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign comp_done_o       = done_q;
  assign num_approx_o      = approx_q;
  assign num_approx_sign_o = approx_sign_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_ame_num_approx.sv
// Bench for ame_num_approx: directed vector table, handshake/reset corner sequences,
// and randomized operands checked against a plain-arithmetic reference model.
module tb_ame_num_approx;

  localparam int N   = 64;
  localparam int SB  = 8;
  localparam int NCH = N / SB;

  logic         clk;
  logic         rst_n;
  logic         comp_init;
  logic [N-1:0] comp_data;

  logic         busy, done, sign;
  logic [N-1:0] approx;
  logic [1:0]   dbg_state;
  logic         busy_t, done_t, sign_t;
  logic [N-1:0] approx_t;
  logic [1:0]   dbg_state_t;

  int total = 0;
  int bad   = 0;
  logic [N:0] exp_q[$];

  ame_num_approx #(.COMP_DATA_BITS(N), .SCAN_BITS(SB), .ROUND_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(comp_init), .comp_data_i(comp_data),
    .busy_o(busy), .comp_done_o(done), .num_approx_o(approx),
    .num_approx_sign_o(sign), .dbg_state_o(dbg_state)
  );

  ame_num_approx #(.COMP_DATA_BITS(N), .SCAN_BITS(SB), .ROUND_EN(0)) dut_trunc (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(comp_init), .comp_data_i(comp_data),
    .busy_o(busy_t), .comp_done_o(done_t), .num_approx_o(approx_t),
    .num_approx_sign_o(sign_t), .dbg_state_o(dbg_state_t)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    logic [N-1:0] exp_ap;
    logic         exp_sg;
    logic [N-1:0] exp_tr;
    int           exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: leading one found by plain search, latency from chunk position.
  function automatic void ref_model(input logic [N-1:0] d, input bit rnd,
                                    output logic [N-1:0] ap, output logic sg, output int lat);
    logic [N-1:0] m;
    int p, q;
    m = d[N-1] ? (~d + 64'd1) : d;
    if (m == 0) begin
      ap = '0; sg = 1'b0; lat = NCH + 1;
    end else begin
      p = N - 1;
      while (!m[p]) p--;
      lat = (NCH - p / SB) + 1;
      q = p;
      if (rnd && p > 0 && m[p-1]) q = p + 1;
      if (q > N - 1) q = N - 1;
      ap = 64'd1 << q;
      sg = d[N-1];
    end
  endfunction

  // Edges after the reference edge until done is seen; -1 on timeout.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    forever begin
      @(posedge clk); n++; #1;
      if (done) return;
      if (n >= 40) begin
        total++; bad++;
        $display("FAIL %s_timeout actual=no_done required=done", nm);
        n = -1;
        return;
      end
    end
  endtask

  task automatic do_op(input logic [N-1:0] d, input logic [N-1:0] ap, input logic sg,
                       input logic [N-1:0] tr, input int lat, input string nm);
    int n;
    logic [N:0] e;
    @(negedge clk);
    comp_init = 1'b1; comp_data = d;
    exp_q.push_back({sg, ap});
    @(posedge clk); #1;
    comp_init = 1'b0;
    comp_data = {$urandom, $urandom};
    check({nm, "_busy"}, N'(busy), N'(1));
    check({nm, "_done_low"}, N'(done), N'(0));
    wait_done(nm, n);
    e = exp_q.pop_front();
    if (n >= 0) begin
      check({nm, "_lat"}, N'(n), N'(lat));
      check({nm, "_approx"}, approx, e[N-1:0]);
      check({nm, "_sign"}, N'(sign), N'(e[N]));
      check({nm, "_trunc"}, approx_t, tr);
      check({nm, "_trunc_done"}, N'(done_t), N'(1));
      check({nm, "_idle"}, N'(busy), N'(0));
    end
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    bit seen;
    logic [N-1:0] d, ap, tr;
    logic sg;
    int lat;

    vecs[0] = '{64'd12, 64'h10, 1'b0, 64'h8, 9};
    vecs[1] = '{-64'sd5, 64'h4, 1'b1, 64'h4, 9};
    vecs[2] = '{64'd1, 64'h1, 1'b0, 64'h1, 9};
    vecs[3] = '{64'd0, 64'h0, 1'b0, 64'h0, 9};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2};
    vecs[5] = '{64'h0180_0000_0000_0000, 64'h0200_0000_0000_0000, 1'b0, 64'h0100_0000_0000_0000, 2};
    vecs[6] = '{64'd3, 64'h4, 1'b0, 64'h2, 9};

    rst_n = 1'b0; comp_init = 1'b0; comp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_approx", approx, '0);
    check("rst_sign", N'(sign), N'(0));
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].data, vecs[i].exp_ap, vecs[i].exp_sg, vecs[i].exp_tr, vecs[i].exp_lat,
            $sformatf("vec%0d", i));

    // Outputs hold while idle.
    repeat (5) @(posedge clk);
    #1;
    check("hold_approx", approx, 64'h4);
    check("hold_done", N'(done), N'(0));

    // Request during busy is dropped; next request lands in the done cycle.
    @(negedge clk); comp_init = 1'b1; comp_data = 64'd3;
    @(posedge clk); #1; comp_init = 1'b0; comp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); comp_init = 1'b1; comp_data = '1;
    @(posedge clk); #1; comp_init = 1'b0;
    check("ign_busy", N'(busy), N'(1));
    wait_done("ign", n);
    if (n >= 0) begin
      check("ign_lat", N'(n), N'(6));
      check("ign_approx", approx, 64'h4);
      check("ign_sign", N'(sign), N'(0));
    end
    do_op('1, 64'h1, 1'b1, 64'h1, 9, "b2b");

    // Reset mid-scan aborts with no done pulse afterwards.
    @(negedge clk); comp_init = 1'b1; comp_data = 64'd12;
    @(posedge clk); #1; comp_init = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", N'(busy), N'(0));
    check("arst_done", N'(done), N'(0));
    check("arst_approx", approx, '0);
    check("arst_sign", N'(sign), N'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("arst_no_done", N'(seen), N'(0));
    do_op(64'd12, 64'h10, 1'b0, 64'h8, 9, "post_rst");

    // Random operands spread over all magnitudes.
    for (int i = 0; i < 60; i++) begin
      d = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) d = ~d + 64'd1;
      if ($urandom_range(0, 9) == 0) d = 64'h8000_0000_0000_0000 >> $urandom_range(0, 2);
      ref_model(d, 1'b1, ap, sg, lat);
      ref_model(d, 1'b0, tr, sg, lat);
      do_op(d, ap, sg, tr, lat, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ame_num_approx.md
AME_NUM_APPROX -- requirements
Module: ame_num_approx

Interface
REQ-001 Parameter: COMP_DATA_BITS, default 64, operand width; SHALL be a multiple of SCAN_BITS.
REQ-002 Parameter: SCAN_BITS, default 8, bits examined per SCAN cycle.
REQ-003 Parameter: ROUND_EN, default 1, 1 = round to nearest power of two, 0 = truncate to leading one.
REQ-004 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 comp_init_i  input  1  start request, sampled only in IDLE.
REQ-007 comp_data_i  input  COMP_DATA_BITS  signed two's-complement operand, sampled with comp_init_i.
REQ-008 busy_o  output  1  high while state != IDLE.
REQ-009 comp_done_o  output  1  one-cycle pulse, result valid.
REQ-010 num_approx_o  output  COMP_DATA_BITS  one-hot power-of-two approximation of |operand|; all-zero for a zero operand.
REQ-011 num_approx_sign_o  output  1  1 when the operand is negative.

Function
REQ-012 Purpose: produce the num_approx/sign pair consumed by the normaliser, which shifts right by the one-hot index and negates on sign.
REQ-013 States: IDLE, SCAN, ROUND; encoded as an FSM register.
REQ-014 IDLE + comp_init_i=1 at edge T: register mag = |comp_data_i| (COMP_DATA_BITS unsigned; the most negative value gives 2^(N-1)) and sign = MSB of comp_data_i; set chunk counter c = N/SCAN_BITS-1; go to SCAN.
REQ-015 IDLE + comp_init_i=0: remain in IDLE; outputs hold.
REQ-016 SCAN, each cycle: examine mag[c*SCAN_BITS +: SCAN_BITS]; if nonzero, record p = index of its highest set bit and go to ROUND; if zero and c>0, decrement c and stay in SCAN; if zero and c==0, set zero flag and go to ROUND.
REQ-017 ROUND: if zero flag, num_approx_o = 0; otherwise q = p+1 when ROUND_EN=1, p>0 and mag[p-1]=1, else q = p; q SHALL saturate at N-1; num_approx_o = 1<<q.
REQ-018 ROUND: num_approx_sign_o = sign AND NOT zero flag; comp_done_o = 1 for exactly one cycle; next state IDLE.
REQ-019 Latency: with k = number of chunks scanned (1..N/SCAN_BITS), comp_done_o SHALL be high in the cycle following edge T+k+1.
REQ-020 num_approx_o and num_approx_sign_o SHALL hold their values until the next ROUND; comp_done_o SHALL be 0 outside the ROUND edge pulse.
REQ-021 comp_init_i while busy_o=1 SHALL be ignored; no queuing.
REQ-022 comp_init_i in the cycle where comp_done_o=1 (state IDLE) SHALL be accepted normally, giving back-to-back operation.
REQ-023 comp_data_i SHALL be ignored except at the acceptance edge.

Reset
REQ-024 rst_n_i low SHALL force state IDLE, busy_o=0, comp_done_o=0, num_approx_o=0, num_approx_sign_o=0, and clear mag, sign, c, p and zero flag.
REQ-025 Reset during SCAN or ROUND SHALL abort the operation; no comp_done_o pulse for it after release.
REQ-026 The first comp_init_i after reset release SHALL be accepted.

Verification (N=64, SCAN_BITS=8, ROUND_EN=1; T = accept edge)
REQ-027 data=+12 -> num_approx_o=0x10, sign=0, done after edge T+9 (k=8).
REQ-028 data=-5 -> num_approx_o=0x4, sign=1; data=+1 -> 0x1, sign=0; both done after edge T+9.
REQ-029 data=0 -> num_approx_o=0, sign=0, done after edge T+9; data=0x8000_0000_0000_0000 -> num_approx_o=0x8000_0000_0000_0000, sign=1, done after edge T+2.
REQ-030 data=0x0180_0000_0000_0000 (p=56, bit55=1) -> num_approx_o=1<<57, done after edge T+2; ROUND_EN=0 with the same data -> 1<<56.
REQ-031 Accept data=+3, pulse comp_init_i with data=-1 at edge T+3 -> second request ignored, result 0x4 sign 0; then re-init in the done cycle -> accepted.
REQ-032 Assert rst_n_i mid-SCAN -> all outputs 0 immediately, no done pulse; the next request completes correctly.
